// File: rtl/led_spi_master.sv
// SPI master that writes one pixel (6-bit address + 24-bit RGB) per 32-bit frame
// to an LED matrix controller: SPI mode 0, MSB first, with a guaranteed CS gap.
module led_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [5:0]  tx_addr,
    input  logic [23:0] tx_rgb,
    output logic        sclk,
    output logic        mosi,
    output logic        cs,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state, state_nx;
    logic [7:0]  div_cnt, div_nx;
    logic [4:0]  bit_cnt, bit_nx;
    logic [30:0] sreg, sreg_nx;
    logic        sclk_nx, mosi_nx, cs_nx, busy_nx, done_nx;
    logic [31:0] frame;

    assign frame    = {2'b00, tx_addr, tx_rgb};
    assign tx_ready = (state == IDLE);

    // NOTE: every output is a flop, so all next values are assigned non-blocking here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            sreg    <= sreg_nx;
            sclk    <= sclk_nx;
            mosi    <= mosi_nx;
            cs      <= cs_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults on every path keep this block free of latches.
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        sreg_nx  = sreg;
        sclk_nx  = sclk;
        mosi_nx  = mosi;
        cs_nx    = cs;
        busy_nx  = busy;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    sreg_nx  = frame[30:0];
                    mosi_nx  = frame[31];
                    cs_nx    = 1'b0;
                    busy_nx  = 1'b1;
                    div_nx   = '0;
                    bit_nx   = '0;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx   = '0;
                    sclk_nx  = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                    if (sclk) begin
                        // Falling edge: the only point where mosi may move.
                        sclk_nx = 1'b0;
                        if (bit_cnt == 5'd31) begin
                            mosi_nx  = 1'b0;
                            state_nx = HOLD;
                        end else begin
                            mosi_nx = sreg[30];
                            sreg_nx = {sreg[29:0], 1'b0};
                            bit_nx  = bit_cnt + 5'd1;
                        end
                    end else begin
                        sclk_nx = 1'b1;
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx   = '0;
                    cs_nx    = 1'b1;
                    state_nx = GAP;
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    div_nx   = '0;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_spi_master.sv
// Directed bench for led_spi_master: default instance (CLK_DIV=4, CS_GAP=8) and a
// fast instance (CLK_DIV=2, CS_GAP=4); outputs are sampled on the falling clock edge.
module tb_led_spi_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_sclk, a_mosi, a_cs, a_busy, a_done;
    logic [5:0]  a_addr;
    logic [23:0] a_rgb;
    logic        b_valid, b_ready, b_sclk, b_mosi, b_cs, b_busy, b_done;
    logic [5:0]  b_addr;
    logic [23:0] b_rgb;

    led_spi_master dut_a (
        .clk(clk), .rst(rst), .tx_valid(a_valid), .tx_ready(a_ready),
        .tx_addr(a_addr), .tx_rgb(a_rgb), .sclk(a_sclk), .mosi(a_mosi),
        .cs(a_cs), .busy(a_busy), .done(a_done)
    );

    led_spi_master #(.CLK_DIV(2), .CS_GAP(4)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(b_valid), .tx_ready(b_ready),
        .tx_addr(b_addr), .tx_rgb(b_rgb), .sclk(b_sclk), .mosi(b_mosi),
        .cs(b_cs), .busy(b_busy), .done(b_done)
    );

    // Selected instance view: 0 = dut_a, 1 = dut_b.
    logic sel = 1'b0;
    logic m_sclk, m_mosi, m_cs, m_busy, m_done, m_ready;
    assign m_sclk  = sel ? b_sclk  : a_sclk;
    assign m_mosi  = sel ? b_mosi  : a_mosi;
    assign m_cs    = sel ? b_cs    : a_cs;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_ready = sel ? b_ready : a_ready;

    int tests = 0;
    int fails = 0;

    logic [31:0] cap_data;
    int          cap_rises, cap_cs_low, cap_done_at, cap_viol, cap_terr, cap_ones, cap_gap_high;
    logic        cap_start_ok;
    int          total_rises;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] ad, input logic [23:0] c);
        if (sel) begin b_valid = v; b_addr = ad; b_rgb = c; end
        else     begin a_valid = v; a_addr = ad; a_rgb = c; end
    endtask

    task automatic set_valid(input logic v);
        if (sel) b_valid = v;
        else     a_valid = v;
    endtask

    // Present a request on the falling edge; the following rising edge accepts it.
    task automatic start(input logic [5:0] ad, input logic [23:0] c);
        @(negedge clk);
        drive(1'b1, ad, c);
    endtask

    // Observe one frame from the accept edge (n=0) to the done pulse.
    task automatic capture(input int cd, input bit hold, input bit mid_change,
                           input logic [5:0] nx_addr, input logic [23:0] nx_rgb,
                           input logic nx_valid);
        logic ps, pm;
        ps = 1'b0; pm = 1'b0;
        cap_data = '0; cap_rises = 0; cap_cs_low = 0; cap_done_at = -1;
        cap_viol = 0; cap_terr = 0; cap_ones = 0; cap_gap_high = 0; cap_start_ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n == 0) begin
                cap_start_ok = (m_cs == 1'b0) && (m_busy == 1'b1) && (m_ready == 1'b0) && (m_done == 1'b0);
                if (!hold) set_valid(1'b0);
            end
            if (mid_change && n == 50)  drive(1'b1, 6'h3F, 24'h000000);
            if (mid_change && n == 150) drive(1'b0, 6'h3F, 24'h000000);
            if (m_sclk && !ps) begin
                if (n != (2 * cap_rises + 1) * cd) cap_terr++;
                cap_data = {cap_data[30:0], m_mosi};
                cap_rises++;
            end
            if (n > 0 && m_mosi !== pm && !(ps && !m_sclk)) cap_viol++;
            if (m_cs && m_sclk !== ps) cap_viol++;
            if (!m_cs) cap_cs_low++;
            else if (n > 0) cap_gap_high++;
            if (m_mosi) cap_ones++;
            if (!m_done && m_ready) cap_viol++;
            if (m_done) begin
                cap_done_at = n;
                if (!(m_ready && !m_busy)) cap_viol++;
                drive(nx_valid, nx_addr, nx_rgb);
                break;
            end
            ps = m_sclk;
            pm = m_mosi;
        end
        total_rises += cap_rises;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, low;
        logic ps;
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_rgb = '0;
        b_valid = 1'b0; b_addr = '0; b_rgb = '0;
        total_rises = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs",    a_cs,    1'b1);
        check("rst_sclk",  a_sclk,  1'b0);
        check("rst_mosi",  a_mosi,  1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_done",  a_done,  1'b0);
        check("rst_ready", a_ready, 1'b1);
        check("rst_b_cs",  b_cs,    1'b1);
        rst = 1'b0;

        // Single write: frame 32'h2AFF8001, cs low 260, done at 268
        start(6'h2A, 24'hFF8001);
        check("single_ready", m_ready, 1'b1);
        capture(4, 0, 0, 6'h2A, 24'hFF8001, 1'b0);
        check("single_start", cap_start_ok, 1'b1);
        check("single_data",  cap_data,     32'h2AFF8001);
        check("single_rises", cap_rises,    32);
        check("single_cslow", cap_cs_low,   260);
        check("single_done",  cap_done_at,  268);
        check("single_timing", cap_terr,    0);
        check("single_viol",  cap_viol,     0);
        @(negedge clk);
        check("single_done_1cyc", a_done, 1'b0);
        check("single_no_reaccept", a_cs, 1'b1);

        // Inputs change while busy: frame keeps the accepted values
        start(6'h11, 24'hABCDEF);
        capture(4, 0, 1, 6'h11, 24'hABCDEF, 1'b0);
        check("latch_data", cap_data,    32'h11ABCDEF);
        check("latch_done", cap_done_at, 268);
        check("latch_viol", cap_viol,    0);
        @(negedge clk);
        check("latch_idle_cs", a_cs, 1'b1);

        // tx_valid held across three frames to addresses 0, 7, 63
        total_rises = 0;
        start(6'd0, 24'h112233);
        capture(4, 1, 0, 6'd7, 24'hA5C3F0, 1'b1);
        check("b2b1_data", cap_data,     32'h00112233);
        check("b2b1_gap",  cap_gap_high, 9);
        capture(4, 1, 0, 6'd63, 24'h00FF00, 1'b1);
        check("b2b2_start", cap_start_ok, 1'b1);
        check("b2b2_data",  cap_data,     32'h07A5C3F0);
        check("b2b2_gap",   cap_gap_high, 9);
        capture(4, 1, 0, 6'd63, 24'h00FF00, 1'b0);
        check("b2b3_start", cap_start_ok, 1'b1);
        check("b2b3_data",  cap_data,     32'h3F00FF00);
        check("b2b3_viol",  cap_viol,     0);
        check("b2b_total_rises", total_rises, 96);
        low = 0;
        repeat (10) begin
            @(negedge clk);
            if (!a_cs) low++;
        end
        check("b2b_no_4th", low, 0);

        // Reset pulsed during rising edge 10
        start(6'h2A, 24'h55AA55);
        r = 0; ps = 1'b0;
        for (int n = 0; n < 400 && r < 11; n++) begin
            @(negedge clk);
            if (n == 0) set_valid(1'b0);
            if (a_sclk && !ps) r++;
            ps = a_sclk;
        end
        check("rstmid_reached", r, 11);
        #1 rst = 1'b1;
        #1;
        check("rstmid_cs",    a_cs,    1'b1);
        check("rstmid_sclk",  a_sclk,  1'b0);
        check("rstmid_mosi",  a_mosi,  1'b0);
        check("rstmid_busy",  a_busy,  1'b0);
        check("rstmid_ready", a_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        low = 0;
        repeat (20) begin
            @(negedge clk);
            if (!a_cs) low++;
        end
        check("rstmid_no_resend", low, 0);
        start(6'h05, 24'h0F0F0F);
        capture(4, 0, 0, 6'h05, 24'h0F0F0F, 1'b0);
        check("rstmid_next_data",  cap_data,    32'h050F0F0F);
        check("rstmid_next_rises", cap_rises,   32);
        check("rstmid_next_done",  cap_done_at, 268);
        check("rstmid_next_timing", cap_terr,   0);

        // Fast instance, CLK_DIV=2 CS_GAP=4, all-zero frame
        sel = 1'b1;
        start(6'd0, 24'd0);
        capture(2, 0, 0, 6'd0, 24'd0, 1'b0);
        check("fast_start",  cap_start_ok, 1'b1);
        check("fast_data",   cap_data,     32'h0);
        check("fast_rises",  cap_rises,    32);
        check("fast_cslow",  cap_cs_low,   130);
        check("fast_done",   cap_done_at,  134);
        check("fast_ones",   cap_ones,     0);
        check("fast_timing", cap_terr,     0);
        check("fast_viol",   cap_viol,     0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
